dnn_sdp_bram: RTL

//  Parametrised simple-dual-port block RAM for DNN weight/activation buffering: 1 write + 1 read port per clk.

---
 rtl/dnn_mem_pkg.sv | 23 ++
 rtl/dnn_sdp_bram_if.sv | 30 +++
 rtl/dnn_bram_clear_seq.sv | 65 ++++++
 rtl/dnn_sdp_bram.sv | 114 +++++++++++
 4 files changed

// File: rtl/dnn_mem_pkg.sv
// Shared types and latency constants for the DNN simple-dual-port BRAM.
// DNN_BRAM_OUT_REG_EN selects the registered-output read latency.
package dnn_mem_pkg;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } bram_state_t;

  localparam int RD_LAT_BASE = 1;
  localparam int RD_LAT_OREG = 2;

`ifdef DNN_BRAM_OUT_REG_EN
  localparam int RD_LAT = RD_LAT_OREG;
`else
  localparam int RD_LAT = RD_LAT_BASE;
`endif

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dnn_sdp_bram_if.sv
// Loader/MAC-side bus of the DNN BRAM: write port, read port, clear control.
// master = client driving requests, slave = the memory.
interface dnn_sdp_bram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  clr;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output clr, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output busy, rd_data, rd_valid
  );

endinterface

// File: rtl/dnn_bram_clear_seq.sv
// Clear sequencer: walks every address once, requesting a zero write per cycle.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_READY | memory available to user reads/writes
//   ST_CLEAR | zeroing mem[cnt_q], one word per clk, user ports held off
module dnn_bram_clear_seq
  import dnn_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  bram_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    case (state_q)
      ST_READY: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_we_o = 1'b1;
        // Counter wraps to zero on the last address, ready for the next clear.
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dnn_sdp_bram.sv
// Simple-dual-port BRAM with byte enables, read-first collisions and a clear sequencer.
// DNN_BRAM_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module dnn_sdp_bram
  import dnn_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input logic          clk,
  input logic          rst,
  dnn_sdp_bram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BYTES = bytes_per_word(DATA_WIDTH);

  if ((DATA_WIDTH % 8) != 0) begin : g_width_check
    $error("dnn_sdp_bram: DATA_WIDTH must be a multiple of 8");
  end

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  dnn_bram_clear_seq #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .CLEAR_ON_RST(CLEAR_ON_RST)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.clr),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  logic wr_acc;
  logic rd_acc;

  assign wr_acc = ~rst & ~busy & bus.wr_en;
  assign rd_acc = ~rst & ~busy & bus.rd_en;

  logic [BYTES-1:0]      mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Single write port shared between the clear sequencer and the loader.
  always_comb begin
    mem_be    = '0;
    mem_addr  = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (busy) begin
      mem_be    = (clr_we & ~rst) ? {BYTES{1'b1}} : '0;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_be = bus.wr_be;
    end
  end

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] arr_rd_q;
  logic                  arr_vld_q;

  // Read samples the array before this edge's write lands: read-first on collision.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (mem_be[b]) begin
        mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    if (rst) begin
      arr_rd_q <= '0;
    end else if (rd_acc) begin
      arr_rd_q <= mem[bus.rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arr_vld_q <= 1'b0;
    end else begin
      arr_vld_q <= rd_acc;
    end
  end

`ifdef DNN_BRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      out_vld_q <= arr_vld_q;
      if (arr_vld_q) begin
        out_data_q <= arr_rd_q;
      end
    end
  end

  assign bus.rd_data  = out_data_q;
  assign bus.rd_valid = out_vld_q;
`else
  assign bus.rd_data  = arr_rd_q;
  assign bus.rd_valid = arr_vld_q;
`endif

  assign bus.busy = busy;

endmodule
